// File: rtl/cartoon_pkg.sv
// Shared types and widths for the cartoonifier pixel pipeline.
// The filter consumes a 3x3 neighbourhood of 24-bit RGB pixels.
package cartoon_pkg;

    localparam int PIXEL_W  = 24;
    localparam int WINDOW_W = 216;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        ACCEPT,
        SETTLE,
        LAUNCH,
        WAIT_DONE
    } wb_state_t;

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel storage with a registered, read-before-write port.
// Maps onto block RAM; contents are never cleared.
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 24,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_q <= mem[rd_addr];
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/window_builder.sv
// Streaming 3x3 window generator: buffers two lines, presents each full window
// to the mean-average filter and stalls intake until the filter reports done.
module window_builder
    import cartoon_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic [23:0]                   pixel_in,
    input  logic                          pixel_valid,
    output logic                          pixel_ready,
    output logic [215:0]                  pixel_data,
    output logic                          mean_average_enable,
    input  logic                          pixel_done,
    output logic [$clog2(IMG_WIDTH)-1:0]  center_col,
    output logic [$clog2(IMG_HEIGHT)-1:0] center_row,
    output logic                          frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    wb_state_t     state_q, state_d;
    logic          cnt_q, cnt_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] ccol_q, ccol_d;
    logic [RW-1:0] crow_q, crow_d;
    logic          last_q, last_d;
    logic          en_q, en_d;
    logic          fd_q, fd_d;
    pixel_t        win_q [9];
    pixel_t        win_d [9];

    logic          accept;
    logic          window_ok;
    logic [CW-1:0] rd_col;
    pixel_t        lb0_rd, lb1_rd;

    assign pixel_ready = (state_q == ACCEPT) && !n_rst;
    assign accept      = pixel_valid && pixel_ready;
    assign window_ok   = (row_q >= RW'(2)) && (col_q >= CW'(2));

    // Read address runs one step ahead so the column's old contents are
    // already registered when the pixel for that column is accepted.
    assign rd_col = n_rst ? '0 : col_d;

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_W)) lb0 (
        .clk     (clk),
        .rd_addr (rd_col),
        .rd_data (lb0_rd),
        .wr_en   (accept),
        .wr_addr (col_q),
        .wr_data (pixel_in)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_W)) lb1 (
        .clk     (clk),
        .rd_addr (rd_col),
        .rd_data (lb1_rd),
        .wr_en   (accept),
        .wr_addr (col_q),
        .wr_data (lb0_rd)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]     = win_q[3*r + 1];
                win_d[3*r + 1] = win_q[3*r + 2];
            end
            win_d[2] = lb1_rd;
            win_d[5] = lb0_rd;
            win_d[8] = pixel_in;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ccol_d  = ccol_q;
        crow_d  = crow_q;
        last_d  = last_q;
        fd_d    = 1'b0;
        case (state_q)
            ACCEPT: begin
                if (accept && window_ok) begin
                    state_d = SETTLE;
                    cnt_d   = 1'b0;
                    ccol_d  = col_q - CW'(1);
                    crow_d  = row_q - RW'(1);
                    last_d  = (col_q == COL_LAST) && (row_q == ROW_LAST);
                end
            end
            SETTLE: begin
                if (cnt_q) begin
                    state_d = LAUNCH;
                end else begin
                    cnt_d = 1'b1;
                end
            end
            LAUNCH: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (pixel_done) begin
                    fd_d    = last_q;
                    state_d = ACCEPT;
                end
            end
            default: begin
                state_d = ACCEPT;
            end
        endcase
        en_d = (state_d == LAUNCH);
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q <= ACCEPT;
            cnt_q   <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            ccol_q  <= '0;
            crow_q  <= '0;
            last_q  <= 1'b0;
            en_q    <= 1'b0;
            fd_q    <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ccol_q  <= ccol_d;
            crow_q  <= crow_d;
            last_q  <= last_d;
            en_q    <= en_d;
            fd_q    <= fd_d;
            win_q   <= win_d;
        end
    end

    // p0 (top-left) lands in the most significant slot.
    for (genvar gi = 0; gi < 9; gi++) begin : g_pack
        assign pixel_data[WINDOW_W-1-PIXEL_W*gi -: PIXEL_W] = win_q[gi];
    end

    assign mean_average_enable = en_q;
    assign frame_done          = fd_q;
    assign center_col          = ccol_q;
    assign center_row          = crow_q;

endmodule

// File: tb/tb_window_builder.sv
// Scoreboard bench for window_builder on a 4x4 frame; pixel i is {i,i,i}.
// The driver queues expected windows, the monitor checks each enable.
module tb_window_builder;

    localparam int W = 4;
    localparam int H = 4;

    logic         clk = 1'b0;
    logic         n_rst;
    logic [23:0]  pixel_in;
    logic         pixel_valid;
    logic         pixel_ready;
    logic [215:0] pixel_data;
    logic         mean_average_enable;
    logic         pixel_done;
    logic [1:0]   center_col;
    logic [1:0]   center_row;
    logic         frame_done;
    logic         done_model = 1'b0;
    logic         done_spur  = 1'b0;

    always #5 clk = ~clk;
    assign pixel_done = done_model | done_spur;

    window_builder #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk                 (clk),
        .n_rst               (n_rst),
        .pixel_in            (pixel_in),
        .pixel_valid         (pixel_valid),
        .pixel_ready         (pixel_ready),
        .pixel_data          (pixel_data),
        .mean_average_enable (mean_average_enable),
        .pixel_done          (pixel_done),
        .center_col          (center_col),
        .center_row          (center_row),
        .frame_done          (frame_done)
    );

    typedef struct {
        logic [215:0] data;
        int           ccol;
        int           crow;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   en_cnt     = 0;
    int   fd_cnt     = 0;
    int   done_delay = 0;
    int   cyc        = 0;
    bit   filter_busy = 1'b0;
    logic done_prev   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check_v(input string name, input logic [215:0] act, input logic [215:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endfunction

    function automatic void check_i(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endfunction

    function automatic logic [215:0] exp_window(input int row, input int col);
        logic [215:0] w;
        logic [7:0]   v;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            v = 8'((row - 2 + k / 3) * W + (col - 2 + k % 3));
            w[215 - 24*k -: 24] = {v, v, v};
        end
        return w;
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (mean_average_enable) begin
            en_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_enable: actual enable at cycle %0d required none", cyc);
            end else begin
                e = exp_q.pop_front();
                $display("window enable: centre (%0d,%0d) data %0h", center_row, center_col, pixel_data);
                check_v("window_data", pixel_data, e.data);
                check_i("center_col", int'(center_col), e.ccol);
                check_i("center_row", int'(center_row), e.crow);
                check_i("enable_latency", cyc + 1 - e.acc, 3);
            end
        end
        if (frame_done) begin
            fd_cnt++;
            check_i("frame_done_after_done", int'(done_prev), 1);
        end
        done_prev = pixel_done;
    end

    // Filter model: done one cycle after enable, plus done_delay extra cycles.
    initial begin
        logic [215:0] snap;
        forever begin
            @(negedge clk);
            if (mean_average_enable) begin
                filter_busy = 1'b1;
                snap = pixel_data;
                @(posedge clk); #1;
                for (int d = 0; d < done_delay; d++) begin
                    @(negedge clk);
                    if (!n_rst) begin
                        check_i("stall_ready", int'(pixel_ready), 0);
                        check_v("stall_data", pixel_data, snap);
                    end
                    @(posedge clk); #1;
                end
                done_model = 1'b1;
                @(posedge clk); #1;
                done_model = 1'b0;
                filter_busy = 1'b0;
            end
        end
    end

    task automatic send_pixel(input int idx);
        int         row;
        int         col;
        bit         got;
        logic [7:0] v;
        exp_t       e;
        row = idx / W;
        col = idx % W;
        got = 1'b0;
        v = 8'(idx);
        pixel_in    = {v, v, v};
        pixel_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (pixel_ready) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL accept_timeout: pixel %0d not accepted within 100 cycles", idx);
        end else begin
            if (row >= 2 && col >= 2) begin
                e.data = exp_window(row, col);
                e.ccol = col - 1;
                e.crow = row - 1;
                e.acc  = cyc + 1;
                exp_q.push_back(e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input int gap_max);
        int n;
        for (int i = 0; i < W * H; i++) begin
            send_pixel(i);
            if (gap_max > 0) begin
                n = int'($urandom_range(0, gap_max));
                if (n > 0) begin
                    pixel_valid = 1'b0;
                    repeat (n) begin
                        @(posedge clk); #1;
                    end
                end
            end
        end
        pixel_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit got;
        got = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !filter_busy && pixel_ready) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL idle_timeout: %0d windows still pending", exp_q.size());
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic frame_checks(input string tag, input int en0, input int fd0, input int exp_en, input int exp_fd);
        check_i({tag, "_enables"}, en_cnt - en0, exp_en);
        check_i({tag, "_frame_done"}, fd_cnt - fd0, exp_fd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  en0;
        int  fd0;
        bit  got;

        n_rst       = 1'b1;
        pixel_valid = 1'b1;
        pixel_in    = 24'habcdef;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_i("reset_ready", int'(pixel_ready), 0);
        check_v("reset_data", pixel_data, '0);
        check_i("reset_enable", int'(mean_average_enable), 0);
        check_i("reset_frame_done", int'(frame_done), 0);
        check_i("reset_center_col", int'(center_col), 0);
        check_i("reset_center_row", int'(center_row), 0);
        @(posedge clk); #1;
        n_rst       = 1'b0;
        pixel_valid = 1'b0;
        @(negedge clk);
        check_i("ready_after_reset", int'(pixel_ready), 1);
        @(posedge clk); #1;

        // Back-to-back frame.
        en0 = en_cnt; fd0 = fd_cnt;
        send_frame(0);
        wait_idle();
        frame_checks("b2b", en0, fd0, 4, 1);

        // Slow filter: intake must stall while done is withheld.
        en0 = en_cnt; fd0 = fd_cnt;
        done_delay = 6;
        send_frame(0);
        wait_idle();
        done_delay = 0;
        frame_checks("slow_done", en0, fd0, 4, 1);

        // Random valid gaps.
        en0 = en_cnt; fd0 = fd_cnt;
        send_frame(3);
        wait_idle();
        frame_checks("gaps", en0, fd0, 4, 1);

        // Spurious done pulses in ACCEPT and SETTLE.
        en0 = en_cnt; fd0 = fd_cnt;
        for (int i = 0; i < 10; i++) send_pixel(i);
        pixel_valid = 1'b0;
        done_spur = 1'b1;
        @(posedge clk); #1;
        done_spur = 1'b0;
        send_pixel(10);
        done_spur = 1'b1;
        @(posedge clk); #1;
        done_spur = 1'b0;
        for (int i = 11; i < W * H; i++) send_pixel(i);
        pixel_valid = 1'b0;
        wait_idle();
        frame_checks("spurious_done", en0, fd0, 4, 1);

        // Reset while waiting for done on the first window.
        en0 = en_cnt; fd0 = fd_cnt;
        done_delay = 4;
        for (int i = 0; i <= 10; i++) send_pixel(i);
        pixel_valid = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (en_cnt > en0) begin
                got = 1'b1;
                break;
            end
        end
        check_i("first_enable_seen", int'(got), 1);
        @(posedge clk); #1;
        n_rst = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        n_rst = 1'b0;
        done_delay = 0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        frame_checks("reset_abandon", en0, fd0, 1, 0);

        // Fresh frame after the abandoned one.
        en0 = en_cnt; fd0 = fd_cnt;
        send_frame(0);
        wait_idle();
        frame_checks("after_reset", en0, fd0, 4, 1);
        check_i("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
